// File: rtl/pixel_stream_src.sv
// Frame-oriented pixel source with ready/valid backpressure and four test patterns.
// Optional inter-pixel throttling is enabled by defining PIXSRC_THROTTLE_EN.
module pixel_stream_src #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned HEIGHT = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  mode,
  input  logic [7:0]  seed,
`ifdef PIXSRC_THROTTLE_EN
  input  logic [3:0]  gap,
`endif
  input  logic        ready_in,
  output logic        valid_out,
  output logic [7:0]  pixel_out,
  output logic        line_end,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
`ifdef PIXSRC_THROTTLE_EN
    , StGap
`endif
  } state_e;

  state_e          state_q;
  logic [1:0]      mode_q;
  logic [7:0]      seed_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [7:0]      lfsr_q;
`ifdef PIXSRC_THROTTLE_EN
  logic [3:0]      gap_q;
  logic [3:0]      gap_cnt_q;
`endif

  logic [XW-1:0]   x_nxt;
  logic [YW-1:0]   y_nxt;
  logic [7:0]      lfsr_nxt;
  logic [7:0]      lfsr_init;
  logic            x_last;
  logic            last_px;
  logic            xfer;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [7:0] pattern(input logic [1:0] m, input logic [7:0] s,
                                         input logic [XW-1:0] px, input logic [YW-1:0] py,
                                         input logic [7:0] l);
    logic [15:0] xe;
    logic [15:0] ye;
    logic [15:0] sum;
    logic [7:0]  p;
    xe  = 16'(px);
    ye  = 16'(py);
    sum = xe + ye;
    unique case (m)
      2'd0:    p = sum[7:0];
      2'd1:    p = s;
      2'd2:    p = l;
      default: p = (xe[3] ^ ye[3]) ? 8'hFF : 8'h00;
    endcase
    return p;
  endfunction

  always_comb begin
    x_last    = (x_q == XW'(WIDTH - 1));
    last_px   = x_last && (y_q == YW'(HEIGHT - 1));
    x_nxt     = x_last ? '0 : x_q + XW'(1);
    y_nxt     = x_last ? y_q + YW'(1) : y_q;
    lfsr_nxt  = lfsr_step(lfsr_q);
    lfsr_init = (seed == 8'h00) ? 8'h01 : seed;
    xfer      = valid_out && ready_in;
    line_end  = (state_q == StRun) && x_last;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      mode_q      <= 2'd0;
      seed_q      <= 8'h00;
      x_q         <= '0;
      y_q         <= '0;
      lfsr_q      <= 8'h01;
      valid_out   <= 1'b0;
      pixel_out   <= 8'h00;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 16'h0000;
`ifdef PIXSRC_THROTTLE_EN
      gap_q       <= 4'd0;
      gap_cnt_q   <= 4'd0;
`endif
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          valid_out <= 1'b0;
          busy      <= 1'b0;
          // abort alongside start suppresses the start
          if (start && !abort) begin
            mode_q    <= mode;
            seed_q    <= seed;
            x_q       <= '0;
            y_q       <= '0;
            lfsr_q    <= lfsr_init;
            pixel_out <= pattern(mode, seed, '0, '0, lfsr_init);
            valid_out <= 1'b1;
            busy      <= 1'b1;
            state_q   <= StRun;
`ifdef PIXSRC_THROTTLE_EN
            gap_q     <= gap;
`endif
          end
        end
        StRun: begin
          if (xfer) begin
            x_q       <= x_nxt;
            y_q       <= y_nxt;
            lfsr_q    <= lfsr_nxt;
            pixel_out <= pattern(mode_q, seed_q, x_nxt, y_nxt, lfsr_nxt);
          end
          if (abort) begin
            valid_out <= 1'b0;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end else if (xfer && last_px) begin
            valid_out   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
            state_q     <= StDone;
          end
`ifdef PIXSRC_THROTTLE_EN
          else if (xfer && gap_q != 4'd0) begin
            valid_out <= 1'b0;
            gap_cnt_q <= gap_q;
            state_q   <= StGap;
          end
`endif
        end
`ifdef PIXSRC_THROTTLE_EN
        StGap: begin
          if (abort) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (gap_cnt_q == 4'd1) begin
            valid_out <= 1'b1;
            state_q   <= StRun;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end
`endif
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_stream_src.sv
// Scoreboard bench for pixel_stream_src: driver queues reference pixels, monitor checks transfers.
module tb_pixel_stream_src;

  localparam int W = 12;
  localparam int H = 9;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [7:0]  seed;
  logic [3:0]  gap;
  logic        ready_in;
  logic        valid_out;
  logic [7:0]  pixel_out;
  logic        line_end;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;

  pixel_stream_src #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .seed       (seed),
`ifdef PIXSRC_THROTTLE_EN
    .gap        (gap),
`endif
    .ready_in   (ready_in),
    .valid_out  (valid_out),
    .pixel_out  (pixel_out),
    .line_end   (line_end),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] px;
    logic       le;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   frames_exp = 0;
  int   done_total = 0;
  int   done_seen = 0;
  int   gap_cur = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: pixel values in raster order straight from the pattern rules.
  task automatic push_frame(input logic [1:0] m, input logic [7:0] s);
    logic [7:0] l;
    exp_t       e;
    int         x;
    int         y;
    l = (s == 8'h00) ? 8'h01 : s;
    for (int i = 0; i < N; i++) begin
      x = i % W;
      y = i / W;
      case (m)
        2'd0:    e.px = 8'((x + y) % 256);
        2'd1:    e.px = s;
        2'd2:    e.px = l;
        default: e.px = ((((x / 8) ^ (y / 8)) % 2) == 1) ? 8'hFF : 8'h00;
      endcase
      e.le = (x == W - 1);
      q.push_back(e);
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
  endtask

  // Monitor: pops one expectation per transfer, checks hold-under-backpressure.
  initial begin
    exp_t       e;
    logic       hold_prev;
    logic [7:0] prev_px;
    int         low_cnt;
    hold_prev = 1'b0;
    prev_px   = 8'h00;
    low_cnt   = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        hold_prev = 1'b0;
        low_cnt   = 0;
      end else begin
        if (valid_out && ready_in) begin
          if (q.size() == 0) begin
            chk("unexpected_pixel", 32'(pixel_out), 32'h100);
          end else begin
            e = q.pop_front();
            chk("pixel", 32'(pixel_out), 32'(e.px));
            chk("line_end", 32'(line_end), 32'(e.le));
          end
        end
        if (frame_done) done_seen++;
        if (hold_prev) begin
          chk("hold_valid", 32'(valid_out), 32'd1);
          chk("hold_pixel", 32'(pixel_out), 32'(prev_px));
        end
        hold_prev = valid_out && !ready_in && !abort;
        prev_px   = pixel_out;
`ifdef PIXSRC_THROTTLE_EN
        if (!busy) low_cnt = 0;
        else if (!valid_out) low_cnt++;
        else if (low_cnt > 0) begin
          chk("gap_len", 32'(low_cnt), 32'(gap_cur));
          low_cnt = 0;
        end
`endif
      end
    end
  end

  // abort_after < 0 runs the frame to completion.
  task automatic run_frame(input logic [1:0] m, input logic [7:0] s, input logic [3:0] g,
                           input int abort_after);
    int   cnt;
    int   cyc;
    logic xfer;
    logic fin;
    @(posedge clk); #1;
    mode  = m;
    seed  = s;
    gap   = g;
`ifdef PIXSRC_THROTTLE_EN
    gap_cur = int'(g);
`endif
    start = 1'b1;
    abort = 1'b0;
    push_frame(m, s);
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_valid", 32'(valid_out), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    cnt = 0;
    cyc = 0;
    fin = 1'b0;
    while (!fin) begin
      ready_in = ($urandom_range(0, 3) != 0);
      start    = ($urandom_range(0, 15) == 0);
      abort    = (cnt == abort_after);
      @(negedge clk);
      xfer = valid_out && ready_in;
      @(posedge clk); #1;
      if (xfer) cnt++;
      if (abort) begin
        fin   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        chk("abort_valid", 32'(valid_out), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_no_done", 32'(frame_done), 32'd0);
        chk("abort_count", 32'(frame_count), 32'(frames_exp));
        q.delete();
      end else if (cnt == N) begin
        fin   = 1'b1;
        start = 1'b0;
        frames_exp = (frames_exp + 1) % 65536;
        done_total++;
        chk("done_pulse", 32'(frame_done), 32'd1);
        chk("done_valid", 32'(valid_out), 32'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(frame_done), 32'd0);
        chk("frame_count", 32'(frame_count), 32'(frames_exp));
        chk("idle_valid", 32'(valid_out), 32'd0);
      end
      cyc++;
      if (!fin && cyc > 5000) begin
        chk("frame_timeout", 32'(cnt), 32'(N));
        fin = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        q.delete();
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(valid_out), 32'd0);
    chk({tag, "_pixel"}, 32'(pixel_out), 32'd0);
    chk({tag, "_line_end"}, 32'(line_end), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
  endtask

  initial begin
    resetn   = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    mode     = 2'd0;
    seed     = 8'h00;
    gap      = 4'd0;
    ready_in = 1'b1;
    #12;
    check_reset_vals("reset");
    resetn = 1'b1;

    run_frame(2'd2, 8'h00, 4'd0, -1);
    run_frame(2'd0, 8'h3C, 4'd1, -1);
    run_frame(2'd3, 8'h00, 4'd2, -1);
    run_frame(2'd1, 8'hA5, 4'd0, -1);
    run_frame(2'd0, 8'h11, 4'd0, 3);
    run_frame(2'd0, 8'h11, 4'd0, -1);
    run_frame(2'd2, 8'h5A, 4'd0, N - 1);

    // start together with abort in IDLE must not begin a frame
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("idle_start_abort_valid", 32'(valid_out), 32'd0);
    chk("idle_start_abort_busy", 32'(busy), 32'd0);

    for (int f = 0; f < 6; f++) begin
      run_frame(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                4'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1);
    end

    // Asynchronous reset in the middle of a frame
    @(posedge clk); #1;
    mode  = 2'd0;
    seed  = 8'h00;
    gap   = 4'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    ready_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    resetn = 1'b0;
    #1;
    check_reset_vals("async_reset");
    #20;
    resetn     = 1'b1;
    ready_in   = 1'b1;
    frames_exp = 0;

    run_frame(2'd0, 8'h00, 4'd0, -1);

    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 32'(done_seen), 32'(done_total));
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_stream_src.md
# pixel_stream_src

Frame-oriented pixel producer that drives the `valid`/`pixel`/`ready` stream input of the SoC's data processor.
- Generates one WIDTH×HEIGHT frame per `start`, from one of four deterministic patterns.
- Fully honours downstream backpressure and reports line and frame boundaries.
- Used as the sensor-side source in SoC benches and as a built-in self-test source on silicon.

## Interface
- WIDTH, 32, pixels per line, ≥ 2
- HEIGHT, 32, lines per frame, ≥ 2

- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  terminate the current frame
- mode  in  2  pattern select, captured at start
- seed  in  8  pattern seed, captured at start
- ready_in  in  1  downstream ready (connects to SoC `ready`)
- valid_out  out  1  pixel valid (connects to SoC `valid`)
- pixel_out  out  8  pixel data (connects to SoC `pixel`)
- line_end  out  1  high while the current pixel is the last of its line
- busy  out  1  high in RUN
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is transferred
- frame_count  out  16  completed frames, wraps 0xFFFF→0

## Operation
- States: IDLE, RUN, DONE.
- Transfer: `valid_out && ready_in` on a rising edge.

IDLE
- `valid_out` = 0, `busy` = 0.
- On `start`:
  - Capture `mode` and `seed`; x = 0, y = 0.
  - lfsr = `seed`, or 0x01 if `seed` = 0.
  - Load `pixel_out` with P(0,0); go to RUN.

RUN
- `valid_out` = 1 and `busy` = 1.
- `pixel_out` is stable until transferred.
- On each transfer:
  - x increments; at x = WIDTH-1, x→0 and y increments.
  - `pixel_out` loads the next pixel value.
- Transfer at (WIDTH-1, HEIGHT-1): go to DONE.

DONE
- Lasts one cycle: `frame_done` = 1 and `frame_count` increments.
- Next state is IDLE.
- `start` during DONE is ignored.

Patterns, all 8-bit with results truncated mod 256:
- Mode 0 RAMP: P = x + y.
- Mode 1 CONST: P = seed.
- Mode 2 LFSR: P = lfsr.
  - Advance on each transfer: lfsr ← {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- Mode 3 CHECKER: P = (x[3]^y[3]) ? 0xFF : 0x00.

Combinational outputs:
- `line_end` = RUN && x = WIDTH-1.

Boundary conditions:
- `start` in RUN or DONE: ignored.
- `abort` in RUN: next state IDLE and `valid_out` drops, even without a transfer.
  - No `frame_done` pulse; `frame_count` unchanged.
- `abort` and transfer in the same cycle: `abort` wins and the pixel counts as transferred.
- `abort` in IDLE: no effect; `start` + `abort` in IDLE: `start` is ignored.
- x/y counter widths: $clog2(WIDTH) and $clog2(HEIGHT).
- No other wrap occurs inside a frame.

## Timing
- Reset values (all outputs): `valid_out`=0, `pixel_out`=0x00, `line_end`=0, `busy`=0, `frame_done`=0, `frame_count`=0.
  - Internal state: IDLE, x=y=0, lfsr=0x01.
- `start` sampled at edge N: `valid_out` = 1 with P(0,0) after edge N.
- With `ready_in` held high: one pixel per cycle, and a frame occupies WIDTH×HEIGHT cycles in RUN.
- `frame_done` is high the cycle after the final transfer.
- Earliest next `start` is sampled on the edge that ends DONE (IDLE cycle).
- `valid_out` never deasserts in RUN without a transfer, except on `abort`.
- All outputs are registered except `line_end`.

## Configuration
- `PIXSRC_THROTTLE_EN` defined:
  - Adds input `gap` (4 bits), captured at `start`.
  - After each transfer that is not the final one, `valid_out` drops for `gap` cycles (sub-state GAP inside RUN, `busy` stays 1), then reasserts with the next pixel.
  - `gap` = 0 behaves as back-to-back; `abort` during GAP goes to IDLE.
- Not defined: the `gap` port does not exist and transfers are back-to-back only.

## Test plan
- WIDTH=4, HEIGHT=2, mode 0, `ready_in`=1:
  - Pixels 00 01 02 03 01 02 03 04 on 8 consecutive cycles.
  - `line_end` on the 4th and 8th pixels; `frame_done` pulse next cycle; `frame_count`=1.
- Same frame with `ready_in` low for 3 cycles while the 2nd pixel is presented: `pixel_out` holds 0x01 and `valid_out` stays 1; the sequence is unchanged.
- Mode 2, seed 0x00: first pixels 0x01, 0x02, 0x04, 0x08, 0x11.
- Mode 1, seed 0xA5; `start` pulsed again mid-frame: exactly 8 pixels of 0xA5 and a single `frame_done`.
- `abort` after 3 transfers: `valid_out` 0 next cycle, no `frame_done`, `frame_count` unchanged. A following `start` restarts at P(0,0).
- `resetn` low mid-frame (asynchronous, between edges): all outputs go to reset values immediately. With `PIXSRC_THROTTLE_EN`, `gap`=2 yields exactly 2 idle cycles between pixels.
